// File: rtl/display_scan_scheduler.sv
// Time-multiplexed scan scheduler for a common-anode multi-digit LED display.
// Double-buffers BCD contents behind a valid/ready handshake so that each frame shows a consistent set of digits.
module display_scan_scheduler #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int BRIGHT_WIDTH = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*NUM_DIGITS-1:0]   load_digits,
  input  logic [BRIGHT_WIDTH-1:0]   brightness,
  input  logic                      lz_blank,
  output logic [NUM_DIGITS-1:0]     digit_select,
  output logic [3:0]                digit_value,
  output logic                      frame_start
);

  localparam int DW      = 4 * NUM_DIGITS;
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ON_W    = $clog2(DWELL_CYCLES + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int STEP    = DWELL_CYCLES >> BRIGHT_WIDTH;

  typedef enum logic [0:0] {S_BLANK, S_DRIVE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic               run;
  logic [ON_W-1:0]    on_cycles;
  logic               supp;
  logic [DW-1:0]      active;
  logic [DW-1:0]      shadow;
  logic               pending;

  function automatic logic [3:0] nibble_at(input logic [DW-1:0] d, input logic [IDX_W-1:0] k);
    return d[DW-4-4*int'(k) +: 4];
  endfunction

  // Bit k set when digits 0..k (counting from the left) are all zero.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [DW-1:0] d);
    logic [NUM_DIGITS-1:0] m;
    logic                  all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      all_zero = all_zero && (d[DW-4-4*k +: 4] == 4'd0);
      m[k]     = all_zero;
    end
    return m;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] strobe(input logic [IDX_W-1:0] k,
                                                  input logic [CNT_W-1:0] dwell,
                                                  input logic [ON_W-1:0]  on,
                                                  input logic             off);
    logic [NUM_DIGITS-1:0] one_hot;
    one_hot = NUM_DIGITS'(1) << (NUM_DIGITS - 1 - int'(k));
    if (!off && (int'(dwell) < int'(on)))
      return ~one_hot;
    return '1;
  endfunction

  logic                  last_idx;
  logic                  blank_done;
  logic                  dwell_done;
  logic                  boundary;
  logic                  accept;
  logic                  entering_blank;
  logic [IDX_W-1:0]      enter_idx;
  logic [DW-1:0]         active_nxt;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  entry_supp;
  logic [ON_W-1:0]       entry_on;

  assign load_ready = !pending;
  assign accept     = load_valid && !pending;

  always_comb begin
    last_idx       = (idx == IDX_W'(NUM_DIGITS - 1));
    blank_done     = (cnt == CNT_W'(BLANK_CYCLES - 1));
    dwell_done     = (cnt == CNT_W'(DWELL_CYCLES - 1));
    boundary       = run && (state == S_DRIVE) && dwell_done && last_idx;
    entering_blank = !run || ((state == S_DRIVE) && dwell_done);
    enter_idx      = (!run || last_idx) ? '0 : idx + IDX_W'(1);

    // A load landing exactly on the boundary with nothing pending bypasses the shadow.
    active_nxt = active;
    if (boundary && pending)
      active_nxt = shadow;
    else if (boundary && accept)
      active_nxt = load_digits;

    lz_mask    = lead_zero_mask(active_nxt);
    entry_supp = lz_blank && lz_mask[enter_idx] && (enter_idx != IDX_W'(NUM_DIGITS - 1));
    entry_on   = ON_W'(int'(brightness) * STEP);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= S_BLANK;
      idx          <= '0;
      cnt          <= '0;
      run          <= 1'b0;
      on_cycles    <= '0;
      supp         <= 1'b0;
      active       <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      digit_select <= '1;
      digit_value  <= 4'd0;
      frame_start  <= 1'b0;
    end else begin
      active <= active_nxt;
      if (accept && !boundary) begin
        shadow  <= load_digits;
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end

      frame_start <= entering_blank && (enter_idx == '0);

      // Strobes are registered one cycle ahead, so they are computed from the next dwell count.
      if (entering_blank) begin
        run          <= 1'b1;
        state        <= S_BLANK;
        idx          <= enter_idx;
        cnt          <= '0;
        digit_value  <= nibble_at(active_nxt, enter_idx);
        on_cycles    <= entry_on;
        supp         <= entry_supp;
        digit_select <= '1;
      end else if (state == S_BLANK) begin
        if (blank_done) begin
          state        <= S_DRIVE;
          cnt          <= '0;
          digit_select <= strobe(idx, '0, on_cycles, supp);
        end else begin
          cnt          <= cnt + CNT_W'(1);
          digit_select <= '1;
        end
      end else begin
        cnt          <= cnt + CNT_W'(1);
        digit_select <= strobe(idx, cnt + CNT_W'(1), on_cycles, supp);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler with a 4-digit, 16-cycle dwell, 2-cycle blank, 2-bit brightness configuration.
// Expected scan output is queued per absolute cycle when stimulus is driven and compared as the DUT produces it.
module tb_display_scan_scheduler;

  localparam int FRAME = 72;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_digits;
  logic [1:0]  brightness;
  logic        lz_blank;
  logic [3:0]  digit_select;
  logic [3:0]  digit_value;
  logic        frame_start;

  display_scan_scheduler #(
    .NUM_DIGITS  (4),
    .DWELL_CYCLES(16),
    .BLANK_CYCLES(2),
    .BRIGHT_WIDTH(2)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_digits (load_digits),
    .brightness  (brightness),
    .lz_blank    (lz_blank),
    .digit_select(digit_select),
    .digit_value (digit_value),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 0 is the first cycle after reset release.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= -1;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [3:0] sel;
    logic [3:0] val;
    logic       fs;
  } exp_t;

  typedef struct packed {
    logic [15:0] digits;
    logic [1:0]  bright;
    logic        lz;
    logic [15:0] on;
  } vec_t;

  exp_t q[$];
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_frame(input int f, input logic [15:0] d, input logic [15:0] on, input int from_p);
    exp_t       e;
    int         dk;
    int         qd;
    logic [3:0] onk;
    logic [3:0] m;
    for (int p = from_p; p < FRAME; p++) begin
      dk    = p / 18;
      qd    = p % 18;
      onk   = on[(3-dk)*4 +: 4];
      m     = 4'b1000 >> dk;
      e.cyc = f * FRAME + p;
      e.val = d[(3-dk)*4 +: 4];
      e.sel = (qd >= 2 && (qd - 2) < int'(onk)) ? ~m : 4'hF;
      e.fs  = (p == 0);
      q.push_back(e);
    end
  endtask

  task automatic wait_phase(input int ph);
    bool_found: begin
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #2;
        if (cyc % FRAME == ph) disable bool_found;
      end
      check("wait_phase_timeout", 32'(ph), 32'hFFFF_FFFF);
    end
  endtask

  task automatic do_load(input logic [15:0] d, output int acc);
    logic r;
    acc         = -1;
    load_digits = d;
    load_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r = load_ready;
      @(posedge clk); #2;
      if (r) begin
        acc = cyc - 1;
        break;
      end
    end
    load_valid = 1'b0;
    if (acc < 0) check("load_timeout", 32'(d), 32'hFFFF_FFFF);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 400 && q.size() > 0; i++) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  vec_t vecs[6];
  int   acc;
  int   acc2;
  int   g;
  int   h;

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    load_valid  = 1'b0;
    load_digits = 16'h0;
    brightness  = 2'd0;
    lz_blank    = 1'b0;

    vecs[0] = '{16'h1234, 2'd3, 1'b0, 16'hCCCC};
    vecs[1] = '{16'h0070, 2'd3, 1'b1, 16'h00CC};
    vecs[2] = '{16'h0070, 2'd0, 1'b1, 16'h0000};
    vecs[3] = '{16'h0000, 2'd2, 1'b1, 16'h0008};
    vecs[4] = '{16'h0905, 2'd1, 1'b1, 16'h0444};
    vecs[5] = '{16'h0905, 2'd3, 1'b0, 16'hCCCC};

    // Scan monitor: pop the expectation for the current cycle and compare.
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          while (q.size() > 0 && q[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL scan_missed cyc=%0d", q[0].cyc);
            void'(q.pop_front());
          end
          if (q.size() > 0 && q[0].cyc == cyc) begin
            n_tests++;
            if (digit_select !== q[0].sel || digit_value !== q[0].val || frame_start !== q[0].fs) begin
              n_fail++;
              $display("FAIL scan cyc=%0d got sel=%b val=%h fs=%b expected sel=%b val=%h fs=%b",
                       cyc, digit_select, digit_value, frame_start, q[0].sel, q[0].val, q[0].fs);
            end
            void'(q.pop_front());
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_select", 32'(digit_select), 32'hF);
    check("rst_value",  32'(digit_value),  32'h0);
    check("rst_fs",     32'(frame_start),  32'h0);
    check("rst_ready",  32'(load_ready),   32'h1);

    push_frame(0, 16'h0000, 16'h0000, 0);
    push_frame(1, 16'h0000, 16'h0000, 0);
    rst = 1'b0;
    wait_empty();

    foreach (vecs[i]) begin
      wait_phase(30);
      brightness = vecs[i].bright;
      lz_blank   = vecs[i].lz;
      do_load(vecs[i].digits, acc);
      push_frame(acc / FRAME + 1, vecs[i].digits, vecs[i].on, 0);
      wait_empty();
    end

    // Backpressure: second offer waits until the cycle after the committing boundary.
    wait_phase(30);
    do_load(16'h1111, acc);
    g = acc / FRAME;
    push_frame(g, 16'h0905, 16'hCCCC, (acc % FRAME) + 1);
    push_frame(g + 1, 16'h1111, 16'hCCCC, 0);
    push_frame(g + 2, 16'h2222, 16'hCCCC, 0);
    check("bp_ready_low", 32'(load_ready), 32'h0);
    do_load(16'h2222, acc2);
    check("bp_accept_cyc", 32'(acc2), 32'((g + 1) * FRAME));
    wait_empty();

    // Load offered exactly in the boundary cycle goes straight to the next frame.
    wait_phase(71);
    h = cyc / FRAME;
    push_frame(h + 1, 16'h5678, 16'hCCCC, 0);
    do_load(16'h5678, acc);
    check("bnd_accept_cyc", 32'(acc), 32'(h * FRAME + 71));
    check("bnd_ready_high", 32'(load_ready), 32'h1);
    wait_empty();

    // Reset during DRIVE of digit 2 with a load pending.
    wait_phase(30);
    do_load(16'h4321, acc);
    check("mid_pending", 32'(load_ready), 32'h0);
    wait_phase(43);
    check("mid_pre_select", 32'(digit_select), 32'hD);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_select", 32'(digit_select), 32'hF);
    check("mid_rst_value",  32'(digit_value),  32'h0);
    check("mid_rst_fs",     32'(frame_start),  32'h0);
    check("mid_rst_ready",  32'(load_ready),   32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    push_frame(0, 16'h0000, 16'hCCCC, 0);
    push_frame(1, 16'h0000, 16'hCCCC, 0);
    rst = 1'b0;
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
